// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : shared encodings for the load/store memory access master
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_align_check.sv
// ============================================================================
// mem_align_check : flags requests whose size/address pair is not naturally
//                   aligned, or whose size encoding is illegal
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_align_check
    import mem_access_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_BYTE:    misaligned_o = 1'b0;
            SIZE_HALF:    misaligned_o = addr_lo_i[0];
            SIZE_WORD:    misaligned_o = (addr_lo_i != 2'b00);
            SIZE_ILLEGAL: misaligned_o = 1'b1;
            default:      misaligned_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_master.sv
// ============================================================================
// mem_access_master : single-outstanding load/store master with alignment
//                     check, bounded wait for mem_good and one-cycle response
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,

    output logic        mem_valid,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_mask,
    output logic        mem_sext,
    input  logic        mem_good,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [31:0]       addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q,  size_d;
    logic              sext_q,  sext_d;
    logic              write_q, write_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              misaligned;

    mem_align_check u_align (
        .size_i       (req_size),
        .addr_lo_i    (req_addr[1:0]),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sext_d  = sext_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    sext_d  = req_sext;
                    write_d = req_write;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (misaligned) begin
                        err_d   = ERR_ALIGN;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // mem_good wins over a timeout landing in the same cycle
                if (mem_good) begin
                    if (!write_q) begin
                        rdata_d = mem_rdata;
                    end
                    err_d   = ERR_OK;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops them at once
    assign req_ready = (state_q == ST_IDLE);

    assign mem_valid = (state_q == ST_ACCESS);
    assign mem_read  = mem_valid & ~write_q;
    assign mem_write = mem_valid &  write_q;
    assign mem_addr  = mem_valid ? addr_q  : '0;
    assign mem_wdata = mem_valid ? wdata_q : '0;
    assign mem_mask  = mem_valid ? size_q  : '0;
    assign mem_sext  = mem_valid & sext_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid ? err_q   : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_master.sv
// ============================================================================
// tb_mem_access_master : directed self-checking bench for mem_access_master
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_valid;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_mask;
    logic        mem_sext;
    logic        mem_good;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_access_master #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_valid (mem_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .mem_sext  (mem_sext),
        .mem_good  (mem_good),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_sext  = 1'b0;
        req_addr  = a;
        req_wdata = wd;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_sext  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_good  = 1'b0;
        mem_rdata = '0;

        // reset state
        repeat (2) step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {30'd0, rsp_err},   32'd0);
        chk("rst_mem_addr",  mem_addr,           32'd0);
        reset = 1'b1;
        step();

        // word load, immediate mem_good
        mem_good  = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 32'h0000_0010, 32'h1234_5678);
        chk("wl_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("wl_mem_read",  {31'd0, mem_read},  32'd1);
        chk("wl_mem_write", {31'd0, mem_write}, 32'd0);
        chk("wl_mem_addr",  mem_addr,           32'h10);
        chk("wl_mem_mask",  {30'd0, mem_mask},  32'd2);
        chk("wl_rsp_early", {31'd0, rsp_valid}, 32'd0);
        chk("wl_ready_busy", {31'd0, req_ready}, 32'd0);
        step();
        chk("wl_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wl_rsp_rdata", rsp_rdata,          32'hDEADBEEF);
        chk("wl_rsp_err",   {30'd0, rsp_err},   32'd0);
        chk("wl_mem_off",   {31'd0, mem_valid}, 32'd0);
        step();
        chk("wl_rsp_done",  {31'd0, rsp_valid}, 32'd0);
        chk("wl_rdata_clr", rsp_rdata,          32'd0);

        // byte store, mem_good already high
        issue(1'b1, 2'b00, 32'h0000_0013, 32'h0000_00A5);
        chk("bs_mem_write", {31'd0, mem_write}, 32'd1);
        chk("bs_mem_read",  {31'd0, mem_read},  32'd0);
        chk("bs_mem_mask",  {30'd0, mem_mask},  32'd0);
        chk("bs_mem_addr",  mem_addr,           32'h13);
        chk("bs_mem_wdata", mem_wdata,          32'hA5);
        step();
        chk("bs_mem_off",   {31'd0, mem_valid}, 32'd0);
        chk("bs_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bs_rsp_err",   {30'd0, rsp_err},   32'd0);
        chk("bs_rsp_rdata", rsp_rdata,          32'd0);
        step();
        mem_good = 1'b0;

        // misaligned half load and illegal size
        issue(1'b0, 2'b01, 32'h0000_0021, 32'd0);
        chk("mh_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("mh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mh_rsp_err",   {30'd0, rsp_err},   32'd1);
        step();
        chk("mh_ready",     {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'b11, 32'h0000_0000, 32'd0);
        chk("il_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("il_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("il_rsp_err",   {30'd0, rsp_err},   32'd1);
        step();
        // misaligned word also short-circuits
        issue(1'b1, 2'b10, 32'h0000_0042, 32'd0);
        chk("mw_rsp_err",   {30'd0, rsp_err},   32'd1);
        step();

        // timeout: 15 ACCESS cycles then rsp_err=10
        mem_rdata = 32'hCAFEF00D;
        issue(1'b0, 2'b10, 32'h0000_0100, 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_mem_valid_%0d", i), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("to_no_rsp_%0d", i),    {31'd0, rsp_valid}, 32'd0);
            step();
        end
        chk("to_mem_off",   {31'd0, mem_valid}, 32'd0);
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err",   {30'd0, rsp_err},   32'd2);
        chk("to_rsp_rdata", rsp_rdata,          32'd0);
        step();
        chk("to_idle",      {31'd0, req_ready}, 32'd1);

        // mem_good on the 15th wait cycle resolves as success
        mem_rdata = 32'h0BAD_CAFE;
        issue(1'b0, 2'b10, 32'h0000_0200, 32'd0);
        for (int i = 0; i < 14; i++) begin
            step();
        end
        chk("g15_mem_valid", {31'd0, mem_valid}, 32'd1);
        mem_good = 1'b1;
        step();
        mem_good = 1'b0;
        chk("g15_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("g15_rsp_err",   {30'd0, rsp_err},   32'd0);
        chk("g15_rsp_rdata", rsp_rdata,          32'h0BAD_CAFE);
        step();

        // asynchronous reset in the 3rd ACCESS cycle
        issue(1'b0, 2'b10, 32'h0000_0300, 32'd0);
        step();
        step();
        chk("ar_pre_valid", {31'd0, mem_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("ar_mem_read",  {31'd0, mem_read},  32'd0);
        chk("ar_ready",     {31'd0, req_ready}, 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("ar_no_rsp",    {31'd0, rsp_valid}, 32'd0);
        chk("ar_ready_rel", {31'd0, req_ready}, 32'd1);
        step();
        chk("ar_no_rsp2",   {31'd0, rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
